// File: rtl/t01_vgacapture.sv
// t01_vgacapture: recovers VGA raster timing from hsync/vsync and emits
// captured active pixels with coordinates, plus sync checking and lock status.
module t01_vgacapture #(
    parameter int H_ACTIVE = 640,
    parameter int H_PULSE  = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_BACK   = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       red,
    input  logic       green,
    input  logic       blue,
    output logic       pixel_valid,
    output logic [9:0] x_out,
    output logic [9:0] y_out,
    output logic [2:0] color_out,
    output logic       frame_start,
    output logic       sync_err,
    output logic       locked
);
    typedef enum logic [2:0] {HS_IDLE, HS_PULSE, HS_BACK, HS_ACTIVE, HS_FRONT} h_state_t;
    typedef enum logic [1:0] {VS_IDLE, VS_BACK, VS_ACTIVE, VS_FRONT} v_state_t;

    h_state_t   h_state, h_next;
    v_state_t   v_state, v_next;
    logic [9:0] h_cnt, h_cnt_next, v_cnt, v_cnt_next;
    logic       hs1, hs2, vs1, vs2, err_seen;
    logic [2:0] rgb1;
    logic       h_fall, h_rise, v_fall, v_rise, line_end, h_err, v_err, err, valid;

    assign h_fall = hs2 & ~hs1;
    assign h_rise = ~hs2 & hs1;
    assign v_fall = vs2 & ~vs1;
    assign v_rise = ~vs2 & vs1;

    always_ff @(posedge clk) begin
        if (rst) begin
            {hs1, hs2, vs1, vs2} <= 4'hf;
            rgb1    <= '0;
            h_state <= HS_IDLE;
            v_state <= VS_IDLE;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            hs1     <= hsync;
            hs2     <= hs1;
            vs1     <= vsync;
            vs2     <= vs1;
            rgb1    <= {red, green, blue};
            h_state <= h_next;
            v_state <= v_next;
            h_cnt   <= h_cnt_next;
            v_cnt   <= v_cnt_next;
        end
    end

    // Back porch exits one count early: the edge-detect cycle already consumed one porch clock.
    always_comb begin
        h_next     = h_state;
        h_cnt_next = h_cnt + 10'd1;
        line_end   = 1'b0;
        h_err      = 1'b0;
        if (h_fall) begin
            h_next     = HS_PULSE;
            h_cnt_next = '0;
            h_err      = h_state == HS_BACK || h_state == HS_ACTIVE;
        end else begin
            case (h_state)
                HS_PULSE: if (h_rise) begin
                    h_next     = HS_BACK;
                    h_cnt_next = '0;
                    h_err      = h_cnt != 10'(H_PULSE - 1);
                end
                HS_BACK: if (h_cnt == 10'(H_BACK - 2)) begin
                    h_next     = HS_ACTIVE;
                    h_cnt_next = '0;
                end
                HS_ACTIVE: if (h_cnt == 10'(H_ACTIVE - 1)) begin
                    h_next     = HS_FRONT;
                    h_cnt_next = '0;
                    line_end   = 1'b1;
                end
                default: h_cnt_next = h_cnt;
            endcase
        end
    end

    // A vsync rise overrides any line-end counted in the same cycle.
    always_comb begin
        v_next     = v_state;
        v_cnt_next = v_cnt;
        v_err      = 1'b0;
        if (v_rise) begin
            v_next     = VS_BACK;
            v_cnt_next = '0;
            v_err      = v_state == VS_ACTIVE;
        end else if (v_fall && (v_state == VS_BACK || v_state == VS_ACTIVE)) begin
            v_next     = VS_FRONT;
            v_cnt_next = '0;
            v_err      = 1'b1;
        end else if (line_end && v_state == VS_BACK) begin
            v_next     = v_cnt == 10'(V_BACK - 1) ? VS_ACTIVE : VS_BACK;
            v_cnt_next = v_cnt == 10'(V_BACK - 1) ? '0 : v_cnt + 10'd1;
        end else if (line_end && v_state == VS_ACTIVE) begin
            v_next     = v_cnt == 10'(V_ACTIVE - 1) ? VS_FRONT : VS_ACTIVE;
            v_cnt_next = v_cnt == 10'(V_ACTIVE - 1) ? '0 : v_cnt + 10'd1;
        end
    end

    always_comb begin
        valid = h_state == HS_ACTIVE && v_state == VS_ACTIVE && !h_fall;
        err   = h_err | v_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_valid <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            color_out   <= '0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
            err_seen    <= 1'b0;
        end else begin
            pixel_valid <= valid;
            x_out       <= valid ? h_cnt : '0;
            y_out       <= valid ? v_cnt : '0;
            color_out   <= valid ? rgb1 : '0;
            frame_start <= valid && h_cnt == '0 && v_cnt == '0;
            sync_err    <= err;
            locked      <= sync_err ? 1'b0 : (v_rise && v_state == VS_FRONT && !err_seen && !err) ? 1'b1 : locked;
            err_seen    <= v_rise ? err : err_seen | err;
        end
    end
endmodule

// File: tb/tb_t01_vgacapture.sv
// tb_t01_vgacapture: drives small-geometry VGA frames with random colours and
// predicts captured pixels from raster rules (lines seen, lines since vsync rise).
module tb_t01_vgacapture;
    localparam int HA = 8, HP = 4, HB = 3, HF = 2, VA = 4, VB = 2, VS = 2, VF = 1;
    localparam int FL = VS + VB + VA + VF, MAXC = 4096, NV = 16;

    typedef struct {int kind; int arg; int exp_err; bit exp_lock;} vec_t;
    typedef struct {bit v; bit [9:0] x; bit [9:0] y; bit [2:0] c; bit fs;} exp_t;

    logic       clk = 0, rst = 1, hsync = 1, vsync = 1, red = 0, green = 0, blue = 0;
    logic       pixel_valid, frame_start, sync_err, locked;
    logic [9:0] x_out, y_out;
    logic [2:0] color_out;

    exp_t exp_q [MAXC];
    vec_t vecs [NV];
    int   cyc = 0, checks = 0, errors = 0, err_cnt = 0, ln = 0, e0;
    bit   prev_err = 0, h_seen = 0, v_seen = 0, vs_now = 1;

    t01_vgacapture #(.H_ACTIVE(HA), .H_PULSE(HP), .H_BACK(HB), .V_ACTIVE(VA), .V_BACK(VB)) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .pixel_valid(pixel_valid), .x_out(x_out), .y_out(y_out), .color_out(color_out),
        .frame_start(frame_start), .sync_err(sync_err), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0 && cyc < MAXC)
            check("pixel", {pixel_valid, x_out, y_out, color_out, frame_start},
                  {exp_q[cyc].v, exp_q[cyc].x, exp_q[cyc].y, exp_q[cyc].c, exp_q[cyc].fs});
        if (prev_err) check("lock_drop", locked, 0);
        if (sync_err) err_cnt++;
        prev_err = sync_err;
    end

    task automatic drive(input logic hs, input logic vs, input logic [2:0] c);
        hsync = hs;
        vsync = vs;
        {red, green, blue} = c;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic vrise();
        v_seen = 1;
        ln = 0;
    endtask

    // A pixel is captured when its line start was seen and V_BACK..V_BACK+V_ACTIVE-1
    // complete lines have elapsed since the last observed vsync rise.
    task automatic line(input bit vsl, input int pw, input int abort_x, input int rst_x, input bit rise_end);
        bit cap;
        int y;
        bit [2:0] c;
        if (vsl && !vs_now) vrise();
        vs_now = vsl;
        for (int i = 0; i < pw; i++) drive(0, vs_now, 3'($urandom));
        h_seen = 1;
        for (int i = 0; i < HB; i++) drive(1, vs_now, 3'($urandom));
        cap = v_seen && ln >= VB && ln < VB + VA;
        y = ln - VB;
        for (int x = 0; x < HA; x++) begin
            if (x == abort_x) return;
            c = 3'($urandom);
            if (x == rst_x) begin
                rst = 1;
                exp_q[cyc + 1] = '{default: 0};
                h_seen = 0;
                v_seen = 0;
                cap = 0;
            end
            if (cap && cyc + 2 < MAXC) exp_q[cyc + 2] = '{1'b1, 10'(x), 10'(y), c, x == 0 && y == 0};
            if (rise_end && x == HA - 1) vs_now = 1;
            drive(1, vs_now, c);
            rst = 0;
        end
        if (h_seen) ln++;
        if (rise_end) vrise();
        for (int i = 0; i < HF; i++) drive(1, vs_now, 3'($urandom));
    endtask

    initial begin
        // kind: 0 clean, 1 short hsync pulse on line arg, 2 hsync abort at x=arg on y=1,
        // 3 reset at x=arg on y=1, 4 vsync rise on the last active pixel of the last sync line
        vecs[0]  = '{0, 0, 0, 1'b0}; vecs[1]  = '{0, 0, 0, 1'b1};
        vecs[2]  = '{1, 3, 1, 1'b0}; vecs[3]  = '{0, 0, 0, 1'b0};
        vecs[4]  = '{0, 0, 0, 1'b1}; vecs[5]  = '{2, 5, 1, 1'b0};
        vecs[6]  = '{0, 0, 0, 1'b0}; vecs[7]  = '{0, 0, 0, 1'b1};
        vecs[8]  = '{3, 3, 0, 1'b0}; vecs[9]  = '{0, 0, 0, 1'b0};
        vecs[10] = '{0, 0, 0, 1'b1}; vecs[11] = '{4, 0, 0, 1'b1};
        vecs[12] = '{0, 0, 0, 1'b1}; vecs[13] = '{2, 0, 1, 1'b0};
        vecs[14] = '{0, 0, 0, 1'b0}; vecs[15] = '{0, 0, 0, 1'b1};
        repeat (3) drive(1, 1, 3'd0);
        check("reset_state", {pixel_valid, x_out, y_out, color_out, frame_start, sync_err, locked}, 0);
        rst = 0;
        repeat (4) drive(1, 1, 3'd0);
        for (int i = 0; i < NV; i++) begin
            e0 = err_cnt;
            for (int l = 0; l < FL; l++)
                line(l >= VS,
                     (vecs[i].kind == 1 && l == VS + vecs[i].arg) ? HP - 1 : HP,
                     (vecs[i].kind == 2 && l == VS + VB + 1) ? vecs[i].arg : -1,
                     (vecs[i].kind == 3 && l == VS + VB + 1) ? vecs[i].arg : -1,
                     vecs[i].kind == 4 && l == VS - 1);
            check($sformatf("sync_err_count_f%0d", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("locked_f%0d", i), locked, vecs[i].exp_lock);
        end
        repeat (4) drive(1, 1, 3'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
